// File: rtl/frame_strobe_sequencer.sv
// Assembles one configuration frame from a 32-bit word stream and then pulses a
// single FrameStrobe bit (one column, one frame) while FrameData is held stable.
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 34,
  parameter int NumColumns      = 60,
  parameter int StrobeCycles    = 2
) (
  input  logic                                   UserCLK,
  input  logic                                   rst,
  input  logic [FrameBitsPerRow-1:0]             in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]     FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0]  FrameStrobe,
  output logic                                   busy,
  output logic                                   err,
  output logic [15:0]                            frames_done
);

  localparam int ROW_W = $clog2(NumRows);
  localparam int IDX_W = $clog2(MaxFramesPerCol * NumColumns);
  localparam int SC_W  = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [7:0]       SYNC     = 8'hFA;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NumRows - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(StrobeCycles - 1);

  typedef enum logic [2:0] {
    HDR     = 3'd0,
    LOAD    = 3'd1,
    DISCARD = 3'd2,
    STROBE  = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t                                state_q, state_d;
  logic [ROW_W-1:0]                      row_cnt_q, row_cnt_d;
  logic [7:0]                            col_q, col_d;
  logic [7:0]                            frame_q, frame_d;
  logic [SC_W-1:0]                       scnt_q, scnt_d;
  logic                                  err_q, err_d;
  logic [15:0]                           frames_done_q, frames_done_d;
  logic [FrameBitsPerRow*NumRows-1:0]    frame_data_q, frame_data_d;
  logic [MaxFramesPerCol*NumColumns-1:0] strobe_q, strobe_d;
  logic                                  in_ready_q, in_ready_d;
  logic                                  busy_q, busy_d;
  logic                                  accept;
  logic [IDX_W-1:0]                      strobe_idx;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready is registered from the state being entered, so it never depends on in_valid.
  assign accept     = in_valid & in_ready_q;
  assign strobe_idx = IDX_W'(col_q) * IDX_W'(MaxFramesPerCol) + IDX_W'(frame_q);

  always_comb begin
    state_d       = state_q;
    row_cnt_d     = row_cnt_q;
    col_d         = col_q;
    frame_d       = frame_q;
    scnt_d        = scnt_q;
    err_d         = err_q;
    frames_done_d = frames_done_q;
    frame_data_d  = frame_data_q;
    case (state_q)
      HDR: begin
        if (accept) begin
          if (in_data[31:24] != SYNC) begin
            err_d = 1'b1;
          end else if ((in_data[23:16] >= 8'(NumColumns)) ||
                       (in_data[15:8] >= 8'(MaxFramesPerCol))) begin
            err_d     = 1'b1;
            row_cnt_d = '0;
            state_d   = DISCARD;
          end else begin
            col_d     = in_data[23:16];
            frame_d   = in_data[15:8];
            row_cnt_d = '0;
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          for (int r = 0; r < NumRows; r++) begin
            if (row_cnt_q == ROW_W'(r)) frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = in_data;
          end
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == ROW_LAST) begin
            state_d       = STROBE;
            scnt_d        = '0;
            frames_done_d = frames_done_q + 16'd1;
          end
        end
      end
      DISCARD: begin
        if (accept) begin
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == ROW_LAST) state_d = HDR;
        end
      end
      STROBE: begin
        if (scnt_q == SC_LAST) state_d = GAP;
        else                   scnt_d  = scnt_q + 1'b1;
      end
      GAP:     state_d = HDR;
      default: state_d = HDR;
    endcase

    in_ready_d = (state_d == HDR) || (state_d == LOAD) || (state_d == DISCARD);
    busy_d     = (state_d != HDR);
    strobe_d   = '0;
    // col_q/frame_q are stable from the header onward, so the strobe target is known on entry.
    if (state_d == STROBE) strobe_d[strobe_idx] = 1'b1;
  end

  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      state_q       <= HDR;
      row_cnt_q     <= '0;
      col_q         <= '0;
      frame_q       <= '0;
      scnt_q        <= '0;
      err_q         <= 1'b0;
      frames_done_q <= '0;
      frame_data_q  <= '0;
      strobe_q      <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      col_q         <= col_d;
      frame_q       <= frame_d;
      scnt_q        <= scnt_d;
      err_q         <= err_d;
      frames_done_q <= frames_done_d;
      frame_data_q  <= frame_data_d;
      strobe_q      <= strobe_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign FrameData   = frame_data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench for frame_strobe_sequencer: header decode, frame load, strobe timing,
// error handling and asynchronous reset, with hand-computed expectations.
module tb_frame_strobe_sequencer;

  localparam int ROWS = 34;
  localparam int W    = 32;
  localparam int SW   = 20 * 60;

  logic              UserCLK = 1'b0;
  logic              rst     = 1'b0;
  logic [W-1:0]      in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W*ROWS-1:0] FrameData;
  logic [SW-1:0]     FrameStrobe;
  logic              busy;
  logic              err;
  logic [15:0]       frames_done;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cyc = 0;
  int onehot_bad = 0;
  int hit65      = 0;
  int hit1199    = 0;

  frame_strobe_sequencer dut (
    .UserCLK     (UserCLK),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err),
    .frames_done (frames_done)
  );

  always #5 UserCLK = ~UserCLK;

  // Strobe activity observed mid-cycle, away from the active edge.
  always @(negedge UserCLK) begin
    if (FrameStrobe != '0) strobe_cyc++;
    if (!$onehot0(FrameStrobe)) onehot_bad++;
    if (FrameStrobe[65]) hit65++;
    if (FrameStrobe[1199]) hit1199++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge UserCLK);
    #1;
    rst = 1'b1;
    tick();
  endtask

  // Offers one word and returns 1 time unit after the edge that accepted it.
  task automatic send_word(input logic [W-1:0] w, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("handshake_wait", 64'(n < 50), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_rows(input logic [W-1:0] base, input int first, input int max_gap);
    for (int r = first; r < ROWS; r++) send_word(base + W'(r), $urandom_range(0, max_gap));
  endtask

  task automatic chk_rows(input string tag, input logic [W-1:0] base, input bit zero);
    logic [W-1:0] exp;
    for (int r = 0; r < ROWS; r++) begin
      exp = zero ? '0 : base + W'(r);
      chk(tag, 64'(FrameData[r*W +: W]), 64'(exp));
    end
  endtask

  initial begin
    int s0;

    // T1: reset holds every output low, in_ready rises one cycle after release
    rst = 1'b0;
    repeat (3) @(posedge UserCLK);
    #1;
    chk("t1_ready_rst", 64'(in_ready), 64'd0);
    chk("t1_busy_rst", 64'(busy), 64'd0);
    chk("t1_err_rst", 64'(err), 64'd0);
    chk("t1_fd_rst", 64'(FrameData != '0), 64'd0);
    chk("t1_fs_rst", 64'(FrameStrobe != '0), 64'd0);
    chk("t1_done_rst", 64'(frames_done), 64'd0);
    rst = 1'b1;
    #2;
    chk("t1_ready_release", 64'(in_ready), 64'd0);
    tick();
    chk("t1_ready_after", 64'(in_ready), 64'd1);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // T2: column 3, frame 5 -> bit 65
    s0 = strobe_cyc;
    send_word(32'hFA03_0500, 0);
    chk("t2_busy_load", 64'(busy), 64'd1);
    send_rows(32'h1000_0000, 0, 0);
    chk("t2_strobe1_bit", 64'(FrameStrobe[65]), 64'd1);
    chk("t2_strobe1_only", 64'(FrameStrobe == (SW'(1) << 65)), 64'd1);
    chk("t2_ready_s1", 64'(in_ready), 64'd0);
    chk("t2_done", 64'(frames_done), 64'd1);
    tick();
    chk("t2_strobe2_bit", 64'(FrameStrobe[65]), 64'd1);
    chk("t2_ready_s2", 64'(in_ready), 64'd0);
    tick();
    chk("t2_gap_strobe", 64'(FrameStrobe != '0), 64'd0);
    chk("t2_ready_gap", 64'(in_ready), 64'd0);
    chk("t2_busy_gap", 64'(busy), 64'd1);
    chk_rows("t2_row_gap", 32'h1000_0000, 1'b0);
    tick();
    chk("t2_ready_hdr", 64'(in_ready), 64'd1);
    chk("t2_busy_hdr", 64'(busy), 64'd0);
    chk("t2_strobe_cycles", 64'(strobe_cyc - s0), 64'd2);
    chk("t2_hit65", 64'(hit65), 64'd2);

    // T3: bad sync is dropped and flags err; a following valid frame still strobes
    do_reset();
    send_word(32'h1203_0500, 0);
    chk("t3_err", 64'(err), 64'd1);
    chk("t3_busy_hdr", 64'(busy), 64'd0);
    chk("t3_ready_hdr", 64'(in_ready), 64'd1);
    send_word(32'hFA03_0500, 0);
    send_rows(32'h2000_0000, 0, 1);
    chk("t3_strobe_bit", 64'(FrameStrobe == (SW'(1) << 65)), 64'd1);
    chk("t3_done", 64'(frames_done), 64'd1);
    chk("t3_err_sticky", 64'(err), 64'd1);
    repeat (3) tick();
    chk_rows("t3_row", 32'h2000_0000, 1'b0);

    // T4: column 60 is out of range -> discard 34 words, no strobe
    do_reset();
    s0 = strobe_cyc;
    send_word(32'hFA3C_0000, 0);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_busy_discard", 64'(busy), 64'd1);
    send_rows(32'hDEAD_0000, 0, 0);
    chk("t4_busy_hdr", 64'(busy), 64'd0);
    chk("t4_ready_hdr", 64'(in_ready), 64'd1);
    repeat (3) tick();
    chk("t4_no_strobe", 64'(strobe_cyc - s0), 64'd0);
    chk("t4_done", 64'(frames_done), 64'd0);
    chk_rows("t4_row_zero", 32'h0, 1'b1);

    // T5: column 59, frame 19 -> bit 1199, with random stalls
    s0 = strobe_cyc;
    send_word(32'hFA3B_1300, 0);
    send_word(32'hA500_0000, 0);
    chk("t5_row0_new", 64'(FrameData[0 +: W]), 64'hA500_0000);
    chk("t5_row1_old", 64'(FrameData[W +: W]), 64'd0);
    repeat (4) tick();
    chk("t5_stall_busy", 64'(busy), 64'd1);
    chk("t5_stall_row1", 64'(FrameData[W +: W]), 64'd0);
    send_rows(32'hA500_0000, 1, 3);
    chk("t5_strobe_bit", 64'(FrameStrobe == (SW'(1) << 1199)), 64'd1);
    chk("t5_done", 64'(frames_done), 64'd1);
    repeat (3) tick();
    chk("t5_strobe_cycles", 64'(strobe_cyc - s0), 64'd2);
    chk("t5_hit1199", 64'(hit1199), 64'd2);
    chk_rows("t5_row", 32'hA500_0000, 1'b0);

    // T6: reset during the first strobe cycle clears everything asynchronously
    do_reset();
    send_word(32'hFA03_0500, 0);
    send_rows(32'h3000_0000, 0, 0);
    chk("t6_strobe_before", 64'(FrameStrobe[65]), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_strobe_async", 64'(FrameStrobe != '0), 64'd0);
    chk("t6_done_rst", 64'(frames_done), 64'd0);
    chk("t6_fd_rst", 64'(FrameData != '0), 64'd0);
    chk("t6_ready_rst", 64'(in_ready), 64'd0);
    chk("t6_busy_rst", 64'(busy), 64'd0);
    rst = 1'b1;
    tick();
    chk("t6_ready_after", 64'(in_ready), 64'd1);
    chk("t6_busy_after", 64'(busy), 64'd0);
    send_word(32'hFA00_0000, 0);
    send_rows(32'h4000_0000, 0, 0);
    chk("t6_strobe_bit0", 64'(FrameStrobe == SW'(1)), 64'd1);
    chk("t6_done_after", 64'(frames_done), 64'd1);
    repeat (3) tick();

    chk("onehot_all_cycles", 64'(onehot_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
